// File: rtl/cmd_link_pkg.sv
// Types and widths shared by both ends of the command link.
// The sender and the receiver must agree on these values.
package cmd_link_pkg;

    localparam int CMD_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic {
        WAIT_HIGH,
        WAIT_LOW
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/cmd_rcvr_uart.sv
// 8N1 UART used by the command link: mid-bit receive sampling and a one-byte transmitter.
// rx_rdy is held until clr_rx_rdy. tx_done is a one-cycle pulse at the end of the stop bit.
module cmd_rcvr_uart
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    output logic              TX,
    output logic              rx_rdy,
    input  logic              clr_rx_rdy,
    output logic [BYTE_W-1:0] rx_data,
    input  logic              trmt,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_done
);

    localparam int                BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(BAUD_DIV / 2);

    logic [1:0]        rx_sync_q;
    logic              rx_busy_q;
    logic [3:0]        rx_bit_q;
    logic [BAUD_W-1:0] rx_baud_q;
    logic [BYTE_W-1:0] rx_shift_q;
    logic              rx_rdy_q;

    logic [BYTE_W+1:0] tx_shift_q;
    logic              tx_busy_q;
    logic [3:0]        tx_bit_q;
    logic [BAUD_W-1:0] tx_baud_q;
    logic              tx_done_q;

    // Starting at half a bit period puts every later sample in the middle of its bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            rx_sync_q  <= 2'b11;
            rx_busy_q  <= 1'b0;
            rx_bit_q   <= 4'd0;
            rx_baud_q  <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RX};
            if (clr_rx_rdy) begin
                rx_rdy_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_bit_q  <= 4'd0;
                    rx_baud_q <= BAUD_HALF;
                end
            end else if (rx_baud_q == BAUD_LAST) begin
                rx_baud_q <= '0;
                rx_bit_q  <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q[1]) begin
                        rx_busy_q <= 1'b0;
                    end
                end else if (rx_bit_q <= 4'd8) begin
                    rx_shift_q <= {rx_sync_q[1], rx_shift_q[BYTE_W-1:1]};
                end else begin
                    rx_busy_q <= 1'b0;
                    rx_rdy_q  <= rx_sync_q[1];
                end
            end else begin
                rx_baud_q <= rx_baud_q + BAUD_W'(1);
            end
        end
    end

    // The shift register refills with ones, so its LSB is the idle-high line as well.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift_q <= '1;
            tx_busy_q  <= 1'b0;
            tx_bit_q   <= 4'd0;
            tx_baud_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (trmt) begin
                    tx_shift_q <= {1'b1, tx_data, 1'b0};
                    tx_busy_q  <= 1'b1;
                    tx_bit_q   <= 4'd0;
                    tx_baud_q  <= '0;
                end
            end else if (tx_baud_q == BAUD_LAST) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[BYTE_W+1:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end else begin
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_baud_q <= tx_baud_q + BAUD_W'(1);
            end
        end
    end

    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_shift_q;
    assign TX      = tx_shift_q[0];
    assign tx_done = tx_done_q;

endmodule

// File: rtl/cmd_rcvr.sv
// Command-link receiver: pairs UART bytes into 16-bit commands (high byte first) and returns response bytes.
// Define CMD_RCVR_TIMEOUT_EN to drop a half-received command after TIMEOUT_CYCLES idle clocks.
module cmd_rcvr
    import cmd_link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int BAUD_DIV       = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RX,
    output logic              TX,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_rdy,
    input  logic              clr_cmd_rdy,
    input  logic [BYTE_W-1:0] resp,
    input  logic              send_resp,
    output logic              resp_sent,
    output logic              frame_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_tmo_range
        $error("cmd_rcvr: TIMEOUT_CYCLES must be at least 2");
    end

    logic              rx_rdy;
    logic              clr_rx_rdy;
    logic              tx_done;
    logic [BYTE_W-1:0] rx_data;

    rx_state_t         rx_state_q, rx_state_d;
    tx_state_t         tx_state_q, tx_state_d;
    logic [BYTE_W-1:0] high_byte_q, high_byte_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              trmt_q, trmt_d;
    logic              resp_sent_q, resp_sent_d;

`ifdef CMD_RCVR_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             frame_err_q, frame_err_d;
`endif

    cmd_rcvr_uart #(
        .BAUD_DIV   (BAUD_DIV)
    ) iUART (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_data    (rx_data),
        .trmt       (trmt_q),
        .tx_data    (tx_data_q),
        .tx_done    (tx_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_q  <= WAIT_HIGH;
            tx_state_q  <= TX_IDLE;
            high_byte_q <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
`ifdef CMD_RCVR_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q  <= rx_state_d;
            tx_state_q  <= tx_state_d;
            high_byte_q <= high_byte_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
`ifdef CMD_RCVR_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        rx_state_d  = rx_state_q;
        high_byte_d = high_byte_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;
        clr_rx_rdy  = 1'b0;
`ifdef CMD_RCVR_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        frame_err_d = 1'b0;
`endif
        // Acknowledge first so a completing low byte in the same cycle overrides it.
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        case (rx_state_q)
            WAIT_HIGH: begin
                if (rx_rdy) begin
                    high_byte_d = rx_data;
                    clr_rx_rdy  = 1'b1;
                    cmd_rdy_d   = 1'b0;
`ifdef CMD_RCVR_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                    rx_state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (rx_rdy) begin
                    cmd_d      = {high_byte_q, rx_data};
                    cmd_rdy_d  = 1'b1;
                    clr_rx_rdy = 1'b1;
                    rx_state_d = WAIT_HIGH;
                end
`ifdef CMD_RCVR_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    rx_state_d  = WAIT_HIGH;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            default: rx_state_d = WAIT_HIGH;
        endcase
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d   = resp;
                    trmt_d      = 1'b1;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;
`ifdef CMD_RCVR_TIMEOUT_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_rcvr.sv
// Directed bench for cmd_rcvr: bench-side UART framing, queue scoreboard for commands and response bytes.
module tb_cmd_rcvr;

    localparam int BAUD = 32;
    localparam int TMO  = 1000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        RX          = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp   = 1'b0;
    logic [7:0]  resp        = 8'h00;
    logic        TX;
    logic        cmd_rdy;
    logic        resp_sent;
    logic        frame_err;
    logic [15:0] cmd;

    int          n_cmp     = 0;
    int          n_err     = 0;
    int          fe_pulses = 0;
    logic [15:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [15:0] last_cmd  = 16'h0000;

    cmd_rcvr #(
        .TIMEOUT_CYCLES (TMO),
        .BAUD_DIV       (BAUD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && frame_err === 1'b1) fe_pulses++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = frame[i];
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    task automatic wait_rx_rdy(output bit ok);
        int cnt = 0;
        ok = 1'b0;
        while (!ok && cnt < 12 * BAUD) begin
            @(negedge clk);
            cnt++;
            if (dut.rx_rdy === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic expect_high(input string tag);
        bit ok;
        wait_rx_rdy(ok);
        check({tag, "_seen"}, 16'(ok), 16'd1);
        @(negedge clk);
        check({tag, "_rdy"}, 16'(cmd_rdy), 16'd0);
        check({tag, "_hold"}, cmd, last_cmd);
    endtask

    task automatic expect_cmd(input string tag, input bit clr_same);
        bit          ok;
        logic [15:0] exp;
        wait_rx_rdy(ok);
        check({tag, "_seen"}, 16'(ok), 16'd1);
        if (clr_same) clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp      = exp_cmd_q.pop_front();
        last_cmd = exp;
        check({tag, "_rdy"}, 16'(cmd_rdy), 16'd1);
        check({tag, "_cmd"}, cmd, exp);
    endtask

    task automatic do_pair(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input bit chk_high, input bit clr_same);
        fork
            send_byte(hi);
            begin
                if (chk_high) expect_high({tag, "_hi"});
            end
        join
        exp_cmd_q.push_back({hi, lo});
        fork
            send_byte(lo);
            expect_cmd(tag, clr_same);
        join
    endtask

    task automatic uart_get(output logic [7:0] b, output bit ok);
        int cnt = 0;
        b  = 8'h00;
        ok = 1'b0;
        while (TX !== 1'b0 && cnt < 4 * BAUD) begin
            @(negedge clk);
            cnt++;
        end
        if (TX !== 1'b0) return;
        repeat (BAUD / 2) @(negedge clk);
        ok = (TX === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        ok = ok && (TX === 1'b1);
    endtask

    initial begin
        bit         ok;
        bit         tx_quiet;
        int         cnt;
        logic [7:0] rx_b;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
        check("rst_resp_sent", 16'(resp_sent), 16'd0);
        check("rst_frame_err", 16'(frame_err), 16'd0);
        check("rst_tx_idle", 16'(TX), 16'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic pair
        do_pair("pair_a53c", 8'hA5, 8'h3C, 1'b1, 1'b0);

        // Consumer acknowledge clears cmd_rdy, cmd holds
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("clr_rdy", 16'(cmd_rdy), 16'd0);
        check("clr_hold", cmd, 16'hA53C);

        // Next pair; then a pair whose high byte must drop cmd_rdy and whose low byte races clr_cmd_rdy
        do_pair("pair_1234", 8'h12, 8'h34, 1'b1, 1'b0);
        do_pair("pair_5678", 8'h56, 8'h78, 1'b1, 1'b1);

        // Response: first request accepted, second one while busy dropped
        resp = 8'hA5;
        @(negedge clk);
        send_resp = 1'b1;
        exp_tx_q.push_back(8'hA5);
        @(negedge clk);
        send_resp = 1'b0;
        resp      = 8'h00;
        fork
            uart_get(rx_b, ok);
            begin
                repeat (3 * BAUD) @(negedge clk);
                resp      = 8'hFF;
                send_resp = 1'b1;
                @(negedge clk);
                send_resp = 1'b0;
                resp      = 8'h00;
            end
        join
        check("tx_frame", 16'(ok), 16'd1);
        check("tx_byte", 16'(rx_b), 16'(exp_tx_q.pop_front()));
        cnt = 0;
        while (resp_sent !== 1'b1 && cnt < 2 * BAUD) begin
            @(negedge clk);
            cnt++;
        end
        check("tx_resp_sent", 16'(resp_sent), 16'd1);
        tx_quiet = 1'b1;
        repeat (12 * BAUD) begin
            @(negedge clk);
            if (TX !== 1'b1) tx_quiet = 1'b0;
        end
        check("tx_second_dropped", 16'(tx_quiet), 16'd1);
        check("tx_resp_sent_hold", 16'(resp_sent), 16'd1);

`ifdef CMD_RCVR_TIMEOUT_EN
        // Lone high byte: the partial command must be dropped after TMO idle cycles
        cnt = 0;
        fork
            send_byte(8'h55);
            begin
                wait_rx_rdy(ok);
                while (frame_err !== 1'b1 && cnt < 2 * TMO) begin
                    @(negedge clk);
                    cnt++;
                end
            end
        join_any
        wait fork;
        check("tmo_seen", 16'(ok), 16'd1);
        check("tmo_window", 16'(cnt >= TMO - 4 && cnt <= TMO + 4), 16'd1);
        @(negedge clk);
        check("tmo_one_cycle", 16'(frame_err), 16'd0);
        check("tmo_cmd_hold", cmd, last_cmd);
        check("tmo_rdy_hold", 16'(cmd_rdy), 16'd0);
        do_pair("tmo_pair", 8'h01, 8'h02, 1'b0, 1'b0);
`endif

        // Reset between high and low byte drops the partial command
        send_byte(8'h77);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_cmd", cmd, 16'h0000);
        check("mid_rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
        check("mid_rst_resp_sent", 16'(resp_sent), 16'd0);
        check("mid_rst_frame_err", 16'(frame_err), 16'd0);
        check("mid_rst_tx", 16'(TX), 16'd1);
        rst_n    = 1'b1;
        last_cmd = 16'h0000;
        repeat (4) @(negedge clk);
        do_pair("pair_beef", 8'hBE, 8'hEF, 1'b1, 1'b0);

`ifdef CMD_RCVR_TIMEOUT_EN
        check("frame_err_pulses", 16'(fe_pulses), 16'd1);
`else
        check("frame_err_pulses", 16'(fe_pulses), 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_rcvr.md
# cmd_rcvr

Receive side of the command link: consumes the serial byte stream produced by the command sender and assembles byte pairs into 16-bit commands, high byte first. It also returns one 8-bit response byte per command over the same UART. It sits between the serial pins and the command-processing logic of the device under control, and instantiates the team's existing UART for the bit-level work.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 100000: inter-byte timeout in clk cycles. Used only when the timeout feature is compiled in.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- RX  input  1  serial data in, from the command sender's TX.
- TX  output  1  serial data out, to the command sender's RX.
- cmd  output  16  last fully assembled command, {high byte, low byte}.
- cmd_rdy  output  1  command valid.
- clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
- resp  input  8  response byte to return.
- send_resp  input  1  one-cycle request to transmit resp.
- resp_sent  output  1  response byte fully transmitted.
- frame_err  output  1  one-cycle pulse when a partial command is discarded by timeout.

## Operation
- All block-owned flops reset synchronously when rst_n=0 at a clk edge.
- Reset values: cmd=16'h0000, cmd_rdy=0, resp_sent=0, frame_err=0, receive FSM=WAIT_HIGH, transmit FSM=TX_IDLE. TX idles at 1.
- Receive FSM:
  - WAIT_HIGH: on UART rx_rdy, capture rx_data into the high_byte register and pulse UART clr_rx_rdy (combinational, same cycle). Clear cmd_rdy, clear the timeout counter, then go to WAIT_LOW.
  - WAIT_LOW: on rx_rdy, load cmd <= {high_byte, rx_data}, set cmd_rdy, pulse clr_rx_rdy, then go to WAIT_HIGH.
- cmd holds its value until the next complete pair arrives. It is never partially updated.
- cmd_rdy is set by low-byte completion and cleared by clr_cmd_rdy or by capture of the next high byte. Set and clr_cmd_rdy in the same cycle: set wins.
- Transmit FSM:
  - TX_IDLE: on send_resp, latch resp into the UART tx_data register, pulse trmt for one cycle, clear resp_sent, then go to TX_BUSY.
  - TX_BUSY: on UART tx_done, set resp_sent, then go to TX_IDLE.
  - send_resp while in TX_BUSY is ignored. The resp value is taken only at the accepted send_resp.
- Receive and transmit paths are independent, and full-duplex operation is legal.

## Timing
- Low-byte rx_rdy seen at edge N: cmd and cmd_rdy are valid after edge N+1.
- clr_rx_rdy is asserted combinationally in the cycle rx_rdy is sampled high in WAIT_HIGH or WAIT_LOW.
- send_resp sampled at edge N: trmt is high in cycle N+1 only. resp_sent rises one cycle after tx_done is seen in TX_BUSY.
- Reset asserted mid-byte: the partial command is dropped, both FSMs return to idle states, and the UART is reset through the same rst_n.

## Configuration
- Macro: CMD_RCVR_TIMEOUT_EN.
- Defined:
  - In WAIT_LOW, the counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 with no rx_rdy, the FSM returns to WAIT_HIGH and frame_err pulses for one cycle.
  - On timeout, high_byte is discarded and cmd and cmd_rdy are unchanged.
  - rx_rdy in the same cycle as expiry: the byte is accepted and no error is raised.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter is built, WAIT_LOW waits indefinitely, and frame_err is tied to 0. The port list is identical in both builds.

## Structure
- Shared package cmd_link_pkg holds:
  - the rx_state_t enum {WAIT_HIGH, WAIT_LOW} and tx_state_t enum {TX_IDLE, TX_BUSY};
  - CMD_W=16 and BYTE_W=8, shared with the command sender.
- One sub-module: the existing UART, instance iUART. All framing, registers and FSMs live in cmd_rcvr.

## Test plan
- Send bytes 8'hA5 then 8'h3C through a bench UART transmitter. Required: cmd=16'hA53C, cmd_rdy=1 one cycle after the low byte's rx_rdy, and frame_err stays 0.
- With cmd_rdy=1, pulse clr_cmd_rdy. Required: cmd_rdy=0 next cycle and cmd holds 16'hA53C. Then send 8'h12, 8'h34. Required: cmd_rdy drops at the high byte and rises with cmd=16'h1234.
- Assert clr_cmd_rdy in the exact cycle the low byte completes. Required: cmd_rdy=1.
- Pulse send_resp with resp=8'hA5, then pulse send_resp again with 8'hFF while busy. Required: a single byte 8'hA5 appears on TX, resp_sent=1 after completion, and the second request is dropped.
- With the timeout built and TIMEOUT_CYCLES=1000, send only 8'h55 and idle. Required: frame_err pulses once about 1000 cycles later. A following pair 8'h01, 8'h02 yields cmd=16'h0102.
- Assert rst_n=0 for one cycle between the high and low bytes. Required: all outputs return to reset values, and the next pair 8'hBE, 8'hEF yields cmd=16'hBEEF.
